sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the successor to the fixed 8-bit FIFO in the user-project wrapper. It generalises data width and depth, and selectable standard or first-word-fall-through (FWFT) read mode. It adds occupancy level, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between the pad-facing wrapper and downstream logic, which instantiates it with per-project parameters.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
FWFT, 0, 0 = standard read (data 1 cycle after rd_en); 1 = head word presented while not empty
AF_THRESH, DEPTH-2, almost_full asserted when level >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of contents and flags
wr_en  in  1  write request
wr_data  in  WIDTH  write data
full  out  1  no free entry
almost_full  out  1  level >= AF_THRESH
rd_en  in  1  read/pop request
rd_data  out  WIDTH  read data
rd_valid  out  1  rd_data valid (see Behaviour)
empty  out  1  no stored entry
almost_empty  out  1  level <= AE_THRESH
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1 at clk edge) sets these values:
  - wr_ptr=rd_ptr=0, level=0, empty=1, full=0.
  - almost_empty=1, almost_full=0.
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Memory contents are not reset.
- Priority: rst > flush > rd/wr.
  - flush gives the same register outcome as reset, except memory contents are retained.
  - wr_en and rd_en in a flush cycle are ignored and set no error flags.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. level is a separate counter.
- Read accepted: rd_acc = rd_en & !empty.
- Write accepted: wr_acc = wr_en & (!full | rd_acc).
  - When full, a simultaneous read and write are both accepted; level is unchanged.
  - When empty, a simultaneous read and write: the read is rejected (underflow set), the write is accepted, and level becomes 1.
- level update each cycle: +1 if wr_acc only, -1 if rd_acc only, otherwise unchanged.
- Flags are registered and consistent with level after the same edge:
  - empty = (level==0), full = (level==DEPTH).
  - almost_full and almost_empty follow the threshold compares against the new level.
- overflow is set when wr_en & !wr_acc. underflow is set when rd_en & empty. Both hold until rst or flush.
- FWFT=0 (standard read):
  - On rd_acc, rd_data <= mem[rd_ptr] at the same edge; rd_valid pulses high for exactly 1 cycle.
  - Read latency is 1 cycle from the rd_en sample edge.
  - rd_data holds its last value otherwise.
- FWFT=1 (first-word-fall-through):
  - rd_data = mem[rd_ptr]; rd_valid = !empty.
  - rd_en pops the head, and the next word appears after that edge.
  - A write into an empty FIFO makes the word visible one cycle after the write edge: empty falls and rd_valid rises together.
- Write-to-read through latency, empty FIFO: empty deasserts 1 cycle after the write edge in both modes.
- Memory may be inferred RAM with registered write. In FWFT mode the read is asynchronous from the registered pointer.

Test Plan:
- Reset then idle (WIDTH=8, DEPTH=4, FWFT=0) -> empty=1, full=0, level=0, almost_empty=1, rd_valid=0, overflow=0, underflow=0.
- Write 0x11,0x22,0x33,0x44 -> full=1, level=4, almost_full=1. Fifth write 0x55 -> overflow=1, level stays 4. Four reads -> rd_data 0x11,0x22,0x33,0x44, each 1 cycle after rd_en. 0x55 is never read.
- Full with simultaneous wr 0xA0 and rd -> level stays 4, no overflow. After draining, 0xA0 is read last. Pointer wrap is verified with 3 fill/drain rounds of 4 words each.
- Empty with simultaneous wr 0x5A and rd -> underflow=1, level=1. The next read returns 0x5A.
- FWFT=1: write 0x77 to an empty FIFO -> next cycle rd_valid=1, rd_data=0x77. Then write 0x88; rd_en -> rd_data=0x88 after the edge, and rd_valid stays 1.
- Fill to 3, set overflow, then assert flush together with wr_en -> level=0, empty=1, overflow=0, and the write is discarded. Also assert rst while level=2 -> all outputs return to their reset values.

Source files
------------

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Brief    : Single-clock FIFO, parametrised width/depth, standard or FWFT read,
//            level, almost flags, flush and sticky overflow/underflow.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam logic [c_LW-1:0] c_DEPTH = c_LW'(DEPTH);
  localparam logic [c_LW-1:0] c_AF    = c_LW'(AF_THRESH);
  localparam logic [c_LW-1:0] c_AE    = c_LW'(AE_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_AW-1:0]  wr_ptr_q;
  logic [c_AW-1:0]  rd_ptr_q;
  logic [c_LW-1:0]  level_q;
  logic [c_LW-1:0]  level_d;
  logic             empty_q;
  logic             full_q;
  logic             af_q;
  logic             ae_q;
  logic             ovf_q;
  logic             udf_q;
  logic             w_rd_acc;
  logic             w_wr_acc;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  always_comb begin
    w_rd_acc = rd_en & ~empty_q;
    w_wr_acc = wr_en & (~full_q | w_rd_acc);
    level_d  = level_q;
    if (w_wr_acc && !w_rd_acc) begin
      level_d = level_q + c_LW'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      level_d = level_q - c_LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (w_wr_acc) wr_ptr_q <= wr_ptr_q + c_AW'(1);
      if (w_rd_acc) rd_ptr_q <= rd_ptr_q + c_AW'(1);
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == c_DEPTH);
      af_q    <= (level_d >= c_AF);
      ae_q    <= (level_d <= c_AE);
      if (wr_en && !w_wr_acc) ovf_q <= 1'b1;
      if (rd_en && empty_q)   udf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word read straight from the array; forced to zero while empty.
      assign rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
      assign rd_valid = ~empty_q;
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= w_rd_acc;
          if (w_rd_acc) rd_data_q <= mem_q[rd_ptr_q];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign full         = full_q;
  assign almost_full  = af_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Brief    : Directed bench for sync_fifo_param, standard and FWFT instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

  localparam int c_DEPTH = 4;

  logic       clk;
  logic       rst;
  // standard-read instance
  logic       s_flush, s_wr_en, s_rd_en;
  logic [7:0] s_wr_data, s_rd_data;
  logic       s_full, s_af, s_rd_valid, s_empty, s_ae, s_ovf, s_udf;
  logic [2:0] s_level;
  // FWFT instance
  logic       f_flush, f_wr_en, f_rd_en;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_full, f_af, f_rd_valid, f_empty, f_ae, f_ovf, f_udf;
  logic [2:0] f_level;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state for the standard instance
  logic [7:0] sb[$];
  int         m_level = 0;
  bit         m_ovf   = 0;
  bit         m_udf   = 0;

  sync_fifo_param #(.WIDTH(8), .DEPTH(c_DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(s_flush),
    .wr_en(s_wr_en), .wr_data(s_wr_data), .full(s_full), .almost_full(s_af),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .empty(s_empty), .almost_empty(s_ae), .level(s_level),
    .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(c_DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(f_flush),
    .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full), .almost_full(f_af),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .empty(f_empty), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_std_flags(input string tag);
    chk({tag, ".level"}, 32'(s_level), 32'(m_level));
    chk({tag, ".empty"}, 32'(s_empty), 32'(m_level == 0));
    chk({tag, ".full"},  32'(s_full),  32'(m_level == c_DEPTH));
    chk({tag, ".af"},    32'(s_af),    32'(m_level >= c_DEPTH - 2));
    chk({tag, ".ae"},    32'(s_ae),    32'(m_level <= 2));
    chk({tag, ".ovf"},   32'(s_ovf),   32'(m_ovf));
    chk({tag, ".udf"},   32'(s_udf),   32'(m_udf));
  endtask

  // One cycle on the standard instance; the model predicts acceptance and
  // the scoreboard supplies the word expected one cycle after an accepted read.
  task automatic s_op(input string tag, input bit we, input bit re, input logic [7:0] d);
    bit racc, wacc;
    logic [7:0] exp;
    s_wr_en   = we;
    s_rd_en   = re;
    s_wr_data = d;
    racc = re && (m_level != 0);
    wacc = we && ((m_level != c_DEPTH) || racc);
    if (wacc) sb.push_back(d);
    if (we && !wacc) m_ovf = 1;
    if (re && m_level == 0) m_udf = 1;
    m_level = m_level + int'(wacc) - int'(racc);
    cyc();
    s_wr_en = 1'b0;
    s_rd_en = 1'b0;
    chk({tag, ".rd_valid"}, 32'(s_rd_valid), 32'(racc));
    if (racc) begin
      exp = sb.pop_front();
      chk({tag, ".rd_data"}, 32'(s_rd_data), 32'(exp));
    end
    chk_std_flags(tag);
  endtask

  task automatic s_flush_op(input string tag, input bit we, input bit re);
    s_flush   = 1'b1;
    s_wr_en   = we;
    s_rd_en   = re;
    s_wr_data = 8'hEE;
    cyc();
    s_flush = 1'b0;
    s_wr_en = 1'b0;
    s_rd_en = 1'b0;
    m_level = 0;
    m_ovf   = 0;
    m_udf   = 0;
    sb.delete();
    chk({tag, ".rd_valid"}, 32'(s_rd_valid), 32'h0);
    chk({tag, ".rd_data"},  32'(s_rd_data),  32'h0);
    chk_std_flags(tag);
  endtask

  initial begin
    rst = 1'b1;
    s_flush = 0; s_wr_en = 0; s_rd_en = 0; s_wr_data = '0;
    f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_wr_data = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // reset state
    chk("rst.rd_valid", 32'(s_rd_valid), 32'h0);
    chk("rst.rd_data",  32'(s_rd_data),  32'h0);
    chk_std_flags("rst");
    chk("rst.f_empty",  32'(f_empty),    32'h1);
    chk("rst.f_valid",  32'(f_rd_valid), 32'h0);

    // fill, overflow, drain in order
    s_op("fill0", 1, 0, 8'h11);
    s_op("fill1", 1, 0, 8'h22);
    s_op("fill2", 1, 0, 8'h33);
    s_op("fill3", 1, 0, 8'h44);
    s_op("ovf",   1, 0, 8'h55);
    for (int i = 0; i < 4; i++) s_op("drain", 0, 1, 8'h00);
    s_op("idle", 0, 0, 8'h00);

    // full with simultaneous read and write
    s_flush_op("clr1", 0, 0);
    s_op("f0", 1, 0, 8'hB0);
    s_op("f1", 1, 0, 8'hB1);
    s_op("f2", 1, 0, 8'hB2);
    s_op("f3", 1, 0, 8'hB3);
    s_op("full_rw", 1, 1, 8'hA0);
    for (int i = 0; i < 4; i++) s_op("drain_a0", 0, 1, 8'h00);

    // pointer wrap: three fill/drain rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) s_op("wrap_w", 1, 0, 8'(8'hC0 + r * 16 + i));
      for (int i = 0; i < 4; i++) s_op("wrap_r", 0, 1, 8'h00);
    end

    // empty with simultaneous read and write
    s_op("empty_rw", 1, 1, 8'h5A);
    s_op("read_5a",  0, 1, 8'h00);

    // flush with write pending while overflow is set
    s_flush_op("clr2", 0, 0);
    for (int i = 0; i < 4; i++) s_op("pf", 1, 0, 8'(8'hD0 + i));
    s_op("pf_ovf", 1, 0, 8'hDF);
    s_op("pf_rd",  0, 1, 8'h00);
    s_flush_op("flush_wr", 1, 0);
    s_op("post_flush_idle", 0, 0, 8'h00);

    // FWFT: fall-through on write to empty, then pop
    f_wr_en   = 1'b1;
    f_wr_data = 8'h77;
    chk("fwft.pre_empty", 32'(f_empty), 32'h1);
    cyc();
    f_wr_en = 1'b0;
    chk("fwft.valid77", 32'(f_rd_valid), 32'h1);
    chk("fwft.data77",  32'(f_rd_data),  32'h77);
    chk("fwft.empty77", 32'(f_empty),    32'h0);
    f_wr_en   = 1'b1;
    f_wr_data = 8'h88;
    cyc();
    f_wr_en = 1'b0;
    chk("fwft.head_hold", 32'(f_rd_data), 32'h77);
    chk("fwft.level2",    32'(f_level),   32'h2);
    f_rd_en = 1'b1;
    cyc();
    f_rd_en = 1'b0;
    chk("fwft.data88",  32'(f_rd_data),  32'h88);
    chk("fwft.valid88", 32'(f_rd_valid), 32'h1);
    chk("fwft.level1",  32'(f_level),    32'h1);
    f_rd_en = 1'b1;
    cyc();
    f_rd_en = 1'b0;
    chk("fwft.drained_valid", 32'(f_rd_valid), 32'h0);
    chk("fwft.drained_empty", 32'(f_empty),    32'h1);
    chk("fwft.udf_clear",     32'(f_udf),      32'h0);

    // reset with data stored
    s_op("pr0", 1, 0, 8'hE1);
    s_op("pr1", 1, 1, 8'hE2);
    s_op("pr2", 1, 0, 8'hE3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_level = 0;
    m_ovf   = 0;
    m_udf   = 0;
    sb.delete();
    chk("rst2.rd_valid", 32'(s_rd_valid), 32'h0);
    chk("rst2.rd_data",  32'(s_rd_data),  32'h0);
    chk_std_flags("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
